noise_filter: RTL and testbench

- Adaptive LMS noise canceller.
- Primary input d carries signal plus noise. Reference input ref_s carries correlated noise.
- An N-tap adaptive FIR estimates the noise from ref_s. The estimate is subtracted from d, and the error e = d - y is the cleaned output.
- Operates at a sample rate set by the clk_en strobe from the surrounding clock-divider logic. All arithmetic is signed Q1.15.

---
 rtl/noise_filter_pkg.sv | 11 +
 rtl/lms_weight_update.sv | 24 ++
 rtl/noise_filter.sv | 81 ++++++++
 tb/tb_noise_filter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/noise_filter_pkg.sv
// noise_filter_pkg: Q-format constant, saturation helper and datapath FSM states
package noise_filter_pkg;
  localparam int FRAC_BITS = 15;
  typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/lms_weight_update.sv
// lms_weight_update: N parallel lanes computing w[k] + ((sat(mu*e) * x[k]) >>> frac), saturated
module lms_weight_update
  import noise_filter_pkg::*;
#(
  parameter int N = 4,
  parameter int DATA_WIDTH = FRAC_BITS + 1
) (
  input  logic signed [DATA_WIDTH-1:0] step_size,
  input  logic signed [DATA_WIDTH-1:0] e,
  input  logic signed [DATA_WIDTH-1:0] x [N],
  input  logic signed [DATA_WIDTH-1:0] w [N],
  output logic signed [DATA_WIDTH-1:0] w_nx [N]
);
  localparam int PW = 2 * DATA_WIDTH;
  logic signed [PW-1:0] mu_e;
  logic signed [DATA_WIDTH-1:0] g;
  assign mu_e = PW'(step_size) * PW'(e);
  assign g = DATA_WIDTH'(sat(64'(mu_e >>> (DATA_WIDTH - 1)), DATA_WIDTH));
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [PW-1:0] gx;
    assign gx = PW'(g) * PW'(x[i]);
    assign w_nx[i] = DATA_WIDTH'(sat(64'(w[i]) + 64'(gx >>> (DATA_WIDTH - 1)), DATA_WIDTH));
  end
endmodule

// File: rtl/noise_filter.sv
// noise_filter: adaptive LMS noise canceller, one MAC per clock, out = sat(d - sum w[k]*x[k])
module noise_filter
  import noise_filter_pkg::*;
#(
  parameter int N = 4,
  parameter int DATA_WIDTH = FRAC_BITS + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         lms_en,
  input  logic signed [DATA_WIDTH-1:0] step_size,
  input  logic signed [DATA_WIDTH-1:0] d,
  input  logic signed [DATA_WIDTH-1:0] ref_s,
  output logic signed [DATA_WIDTH-1:0] out
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + $clog2(N);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state, state_nx;
  logic [CW-1:0] idx;
  logic signed [DATA_WIDTH-1:0] x [N];
  logic signed [DATA_WIDTH-1:0] w [N];
  logic signed [DATA_WIDTH-1:0] w_nx [N];
  logic signed [DATA_WIDTH-1:0] d_q, y, e;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic cap, mac, err, upd, last;
  assign last = idx == CW'(N - 1);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (clk_en ? MAC : IDLE) :
               state == MAC  ? (last ? ERR : MAC) :
               state == ERR  ? UPD : IDLE;
  always_comb begin
    cap = state == IDLE && clk_en;
    mac = state == MAC;
    err = state == ERR;
    upd = state == UPD && lms_en;
  end
  assign prod = PW'(w[idx]) * PW'(x[idx]);
  always_comb begin
    y = DATA_WIDTH'(sat(64'(acc >>> (DATA_WIDTH - 1)), DATA_WIDTH));
    e = DATA_WIDTH'(sat(64'(d_q) - 64'(y), DATA_WIDTH));
  end
  // x and w stay put while busy, so the update sees exactly the operands that produced e
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        x[k] <= '0;
        w[k] <= '0;
      end
      d_q <= '0;
      acc <= '0;
      idx <= '0;
      out <= '0;
    end else begin
      if (cap) begin
        d_q <= d;
        x[0] <= ref_s;
        for (int k = 1; k < N; k++) x[k] <= x[k-1];
        acc <= '0;
        idx <= '0;
      end
      if (mac) begin
        acc <= acc + AW'(prod);
        idx <= idx + 1'b1;
      end
      if (err) out <= e;
      if (upd) w <= w_nx;
    end
  lms_weight_update #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_upd (
    .step_size(step_size),
    .e(out),
    .x(x),
    .w(w),
    .w_nx(w_nx)
  );
endmodule

// File: tb/tb_noise_filter.sv
// tb_noise_filter: directed vector table plus hand sequences checked against an LMS reference model
module tb_noise_filter;
  localparam int N = 4;
  localparam int DW = 16;
  logic clk = 0, rst_n = 1, clk_en = 0, lms_en = 0;
  logic signed [DW-1:0] step_size = '0, d = '0, ref_s = '0, out;
  int n_chk = 0, n_fail = 0;
  longint mx [N], mw [N];
  typedef struct {
    bit rst; bit lms; int step; int dd; int rr; int exp_out; bit chk_w; int w0; int w1;
  } vec_t;
  vec_t tbl [18];

  noise_filter #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .lms_en(lms_en),
    .step_size(step_size), .d(d), .ref_s(ref_s), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
  endtask

  task automatic model(input bit lms, input int step, input int dd, input int rr, output longint e);
    longint acc, y, g;
    for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = rr;
    acc = 0;
    for (int k = 0; k < N; k++) acc += mw[k] * mx[k];
    y = sat16(acc >>> 15);
    e = sat16(dd - y);
    if (lms) begin
      g = sat16((longint'(step) * e) >>> 15);
      for (int k = 0; k < N; k++) mw[k] = sat16(mw[k] + ((g * mx[k]) >>> 15));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1;
    clk_en = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    model_clear();
  endtask

  task automatic run(input bit lms, input int step, input int dd, input int rr,
                     output logic signed [DW-1:0] early, output logic signed [DW-1:0] got);
    @(negedge clk);
    lms_en = lms;
    step_size = DW'(step);
    d = DW'(dd);
    ref_s = DW'(rr);
    clk_en = 1;
    @(negedge clk);
    clk_en = 0;
    early = out;
    repeat (N + 2) @(negedge clk);
    got = out;
  endtask

  initial begin
    logic signed [DW-1:0] early, got;
    longint prev, e;
    tbl[0] = '{1'b1, 1'b0, 0, 1000, 0, 1000, 1'b0, 0, 0};
    for (int i = 1; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 0, 8192, 16384, 8192, 1'b0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 16384, 8192, 16384, 8192, 1'b1, 2048, 0};
    tbl[12] = '{1'b0, 1'b1, 16384, 8192, 16384, 7168, 1'b1, 3840, 1792};
    tbl[13] = '{1'b0, 1'b0, 16384, 8192, 16384, 5376, 1'b1, 3840, 1792};
    tbl[14] = '{1'b0, 1'b0, 16384, 8192, 16384, 5376, 1'b1, 3840, 1792};
    tbl[15] = '{1'b1, 1'b1, 32767, 32767, -32768, 32767, 1'b1, -32766, 0};
    tbl[16] = '{1'b0, 1'b0, 32767, 32767, 32767, 32767, 1'b0, 0, 0};
    tbl[17] = '{1'b0, 1'b0, 32767, -32768, -32768, -32768, 1'b0, 0, 0};

    repeat (3) @(negedge clk);
    rst_n = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_out", out, 0);
    for (int k = 0; k < N; k++) check($sformatf("reset_w%0d", k), dut.w[k], 0);

    prev = 0;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) begin
        do_reset();
        prev = 0;
      end
      run(tbl[i].lms, tbl[i].step, tbl[i].dd, tbl[i].rr, early, got);
      check($sformatf("hold_%0d", i), early, prev);
      check($sformatf("vec_%0d", i), got, tbl[i].exp_out);
      if (tbl[i].chk_w) begin
        check($sformatf("vec_%0d_w0", i), dut.w[0], tbl[i].w0);
        check($sformatf("vec_%0d_w1", i), dut.w[1], tbl[i].w1);
      end
      prev = tbl[i].exp_out;
    end

    // a strobe arriving mid-computation must be dropped
    do_reset();
    @(negedge clk);
    lms_en = 0; d = 500; ref_s = 100; clk_en = 1;
    @(negedge clk);
    clk_en = 0;
    repeat (2) @(negedge clk);
    d = 9999; ref_s = 7777; clk_en = 1;
    @(negedge clk);
    clk_en = 0;
    repeat (N + 2) @(negedge clk);
    check("drop_out", out, 500);
    check("drop_x0", dut.x[0], 100);
    check("drop_x1", dut.x[1], 0);

    // asynchronous reset in the middle of a computation
    do_reset();
    run(1'b1, 16384, 8192, 16384, early, got);
    check("pre_async_out", got, 8192);
    @(negedge clk);
    lms_en = 0; d = 5; ref_s = 300; clk_en = 1;
    @(negedge clk);
    clk_en = 0;
    @(negedge clk);
    #2 rst_n = 1;
    #1;
    check("async_out", out, 0);
    check("async_w0", dut.w[0], 0);
    check("async_x0", dut.x[0], 0);
    @(negedge clk);
    rst_n = 0;
    model_clear();
    run(1'b0, 0, 1000, 0, early, got);
    check("post_async_out", got, 1000);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      model(1'b1, 32767, 32767, -32768, e);
      run(1'b1, 32767, 32767, -32768, early, got);
      check($sformatf("sat_seq_%0d", i), got, e);
    end

    do_reset();
    for (int i = 0; i < 24; i++) begin
      int rr, dd;
      rr = ((i * 3571) % 16001) - 8000;
      dd = (i % 5) * 1000 - 2000 + rr / 2;
      model(1'b1, 655, dd, rr, e);
      run(1'b1, 655, dd, rr, early, got);
      check($sformatf("stream_%0d", i), got, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
